// File: rtl/bsg_fsb_htif_scheduler_pkg.sv
// Ring packet layout shared with the FSB node, plus scheduler-local constants.
package bsg_fsb_pkg;

    typedef struct packed {
        logic [3:0]  srcid;
        logic [3:0]  destid;
        logic [0:0]  cmd;
        logic [6:0]  opcode;
        logic [63:0] data;
    } RingPacketType;

endpackage

package bsg_fsb_htif_scheduler_pkg;

    // cmd value carried by HTIF data packets; anything else is not ours
    localparam logic [0:0] CMD_DATA = 1'b0;

    // channel id lives in the low nibble of opcode
    localparam int unsigned CHAN_ID_WIDTH = 4;

    localparam int unsigned DROP_COUNT_WIDTH = 8;

    // index width that stays legal for a single-entry table
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_fsb_htif_scheduler_if.sv
// HTIF-side and FSB-side handshake bundle of the scheduler.
interface bsg_fsb_htif_scheduler_if #(
    parameter int unsigned num_chan_p   = 4,
    parameter int unsigned htif_width_p = 16,
    parameter int unsigned fsb_width_p  = 80
);

    logic [num_chan_p-1:0]              htif_v_i;
    logic [num_chan_p*htif_width_p-1:0] htif_data_i;
    logic [num_chan_p-1:0]              htif_ready_o;
    logic [num_chan_p-1:0]              htif_v_o;
    logic [htif_width_p-1:0]            htif_data_o;
    logic [num_chan_p-1:0]              htif_ready_i;
    logic                               fsb_v_o;
    logic [fsb_width_p-1:0]             fsb_data_o;
    logic                               fsb_yumi_i;
    logic                               fsb_v_i;
    logic [fsb_width_p-1:0]             fsb_data_i;
    logic                               fsb_ready_o;
    logic [7:0]                         drop_count_o;

    // scheduler side
    modport slave (
        input  htif_v_i, htif_data_i, htif_ready_i, fsb_yumi_i, fsb_v_i, fsb_data_i,
        output htif_ready_o, htif_v_o, htif_data_o, fsb_v_o, fsb_data_o, fsb_ready_o,
        drop_count_o
    );

    // hosts / ring node side
    modport master (
        output htif_v_i, htif_data_i, htif_ready_i, fsb_yumi_i, fsb_v_i, fsb_data_i,
        input  htif_ready_o, htif_v_o, htif_data_o, fsb_v_o, fsb_data_o, fsb_ready_o,
        drop_count_o
    );

endinterface

// File: rtl/bsg_fsb_htif_scheduler_credit.sv
// Per-channel outstanding-request credit counter, saturating at max_val_p.
module bsg_fsb_htif_scheduler_credit #(
    parameter  int unsigned max_val_p = 4,
    localparam int unsigned width_lp  = $clog2(max_val_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                up_i,
    input  logic                down_i,
    output logic [width_lp-1:0] count_o
);

    localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);
    localparam logic [width_lp-1:0] one_lp = width_lp'(1);

    logic [width_lp-1:0] count_q, count_d;

    // simultaneous up and down cancel; a response on a full counter is absorbed
    always_comb begin
        count_d = count_q;
        if (up_i && !down_i && (count_q != max_lp)) begin
            count_d = count_q + one_lp;
        end else if (down_i && !up_i && (count_q != '0)) begin
            count_d = count_q - one_lp;
        end
    end

    // counter register, full on reset
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= max_lp;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_fsb_htif_scheduler_rr_arb.sv
// Combinational round-robin arbiter; the pointer is owned by the caller.
module bsg_fsb_htif_scheduler_rr_arb
    import bsg_fsb_htif_scheduler_pkg::*;
#(
    parameter  int unsigned ways_p   = 4,
    localparam int unsigned idx_w_lp = idx_width(ways_p)
) (
    input  logic [ways_p-1:0]   reqs_i,
    input  logic [idx_w_lp-1:0] ptr_i,
    output logic [ways_p-1:0]   grants_o,
    output logic [idx_w_lp-1:0] tag_o,
    output logic                v_o
);

    // first requester at or above ptr_i wins, otherwise first one below it
    always_comb begin
        grants_o = '0;
        tag_o    = '0;
        v_o      = 1'b0;
        for (int unsigned i = 0; i < ways_p; i++) begin
            if (!v_o && (i >= 32'(ptr_i)) && reqs_i[i]) begin
                v_o         = 1'b1;
                grants_o[i] = 1'b1;
                tag_o       = i[idx_w_lp-1:0];
            end
        end
        for (int unsigned i = 0; i < ways_p; i++) begin
            if (!v_o && (i < 32'(ptr_i)) && reqs_i[i]) begin
                v_o         = 1'b1;
                grants_o[i] = 1'b1;
                tag_o       = i[idx_w_lp-1:0];
            end
        end
    end

endmodule

// File: rtl/bsg_fsb_htif_scheduler.sv
// Shares one FSB ring node among several HTIF channels: credit-limited
// round-robin transmit into a one-entry packet register, and channel-routed
// receive through a one-entry response register with drop counting.
module bsg_fsb_htif_scheduler
    import bsg_fsb_pkg::*;
    import bsg_fsb_htif_scheduler_pkg::*;
#(
    parameter int unsigned num_chan_p   = 4,
    parameter int unsigned htif_width_p = 16,
    parameter int unsigned credits_p    = 4,
    parameter logic [3:0]  destid_p     = 4'd0,
    parameter logic [3:0]  srcid_p      = 4'd0,
    parameter int unsigned fsb_width_p  = 80
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bsg_fsb_htif_scheduler_if.slave io
);

    localparam int unsigned ptr_w_lp  = idx_width(num_chan_p);
    localparam int unsigned cred_w_lp = $clog2(credits_p + 1);
    localparam logic [ptr_w_lp-1:0] ptr_one_lp  = ptr_w_lp'(1);
    localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(num_chan_p - 1);
    localparam logic [DROP_COUNT_WIDTH-1:0] drop_one_lp = DROP_COUNT_WIDTH'(1);

    logic [ptr_w_lp-1:0]          rr_q, rr_d;
    logic                         tx_v_q, tx_v_d;
    RingPacketType                tx_pkt_q, tx_pkt_d;
    logic                         rx_v_q, rx_v_d;
    logic [CHAN_ID_WIDTH-1:0]     rx_ch_q, rx_ch_d;
    logic [htif_width_p-1:0]      rx_data_q, rx_data_d;
    logic [DROP_COUNT_WIDTH-1:0]  drop_q, drop_d;

    logic [num_chan_p-1:0]        eligible, grant, deliver, htif_v_vec;
    logic [ptr_w_lp-1:0]          grant_idx;
    logic                         grant_v;
    logic [htif_width_p-1:0]      grant_word;
    logic [cred_w_lp-1:0]         credit [num_chan_p];
    logic                         tx_can_load;

    logic [fsb_width_p-1:0]       fsb_in, fsb_out;
    RingPacketType                rx_pkt;
    logic [CHAN_ID_WIDTH-1:0]     rx_pkt_ch;
    logic                         rx_routable, rx_accept, rx_deliver, fsb_ready;
    logic                         rx_pkt_unused;

    for (genvar i = 0; i < num_chan_p; i++) begin : g_credit
        bsg_fsb_htif_scheduler_credit #(
            .max_val_p(credits_p)
        ) u_credit (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .up_i     (deliver[i]),
            .down_i   (grant[i]),
            .count_o  (credit[i])
        );
    end

    bsg_fsb_htif_scheduler_rr_arb #(
        .ways_p(num_chan_p)
    ) u_arb (
        .reqs_i  (eligible),
        .ptr_i   (rr_q),
        .grants_o(grant),
        .tag_o   (grant_idx),
        .v_o     (grant_v)
    );

    assign tx_can_load = !tx_v_q || io.fsb_yumi_i;

    // per-channel TX eligibility, RX presentation and RX delivery
    always_comb begin
        eligible   = '0;
        htif_v_vec = '0;
        deliver    = '0;
        for (int unsigned i = 0; i < num_chan_p; i++) begin
            eligible[i]   = io.htif_v_i[i] && (credit[i] != '0) && tx_can_load;
            htif_v_vec[i] = rx_v_q && (rx_ch_q == i[CHAN_ID_WIDTH-1:0]);
            deliver[i]    = htif_v_vec[i] && io.htif_ready_i[i];
        end
    end

    // mux the granted channel's request word
    always_comb begin
        grant_word = '0;
        for (int unsigned i = 0; i < num_chan_p; i++) begin
            if (grant[i]) begin
                grant_word = io.htif_data_i[i*htif_width_p +: htif_width_p];
            end
        end
    end

    // TX register refill on grant (may coincide with yumi), drain on yumi; pointer follows grant
    always_comb begin
        tx_v_d   = tx_v_q;
        tx_pkt_d = tx_pkt_q;
        rr_d     = rr_q;
        if (grant_v) begin
            tx_v_d          = 1'b1;
            tx_pkt_d.srcid  = srcid_p;
            tx_pkt_d.destid = destid_p;
            tx_pkt_d.cmd    = CMD_DATA;
            tx_pkt_d.opcode = 7'(grant_idx);
            tx_pkt_d.data   = 64'(grant_word);
            rr_d            = (grant_idx == ptr_last_lp) ? '0 : grant_idx + ptr_one_lp;
        end else if (io.fsb_yumi_i) begin
            tx_v_d = 1'b0;
        end
    end

    assign fsb_in        = io.fsb_data_i;
    assign rx_pkt        = fsb_in;
    assign rx_pkt_unused = ^rx_pkt;
    assign rx_pkt_ch     = rx_pkt.opcode[CHAN_ID_WIDTH-1:0];
    assign rx_routable   = (rx_pkt.cmd == CMD_DATA) && (32'(rx_pkt_ch) < num_chan_p);
    assign rx_deliver    = |deliver;
    assign fsb_ready     = !rx_v_q || rx_deliver;
    assign rx_accept     = io.fsb_v_i && fsb_ready;

    // RX register load on a routable packet, clear on delivery
    always_comb begin
        rx_v_d    = rx_v_q;
        rx_ch_d   = rx_ch_q;
        rx_data_d = rx_data_q;
        if (rx_accept && rx_routable) begin
            rx_v_d    = 1'b1;
            rx_ch_d   = rx_pkt_ch;
            rx_data_d = rx_pkt.data[htif_width_p-1:0];
        end else if (rx_deliver) begin
            rx_v_d = 1'b0;
        end
    end

    // saturating count of consumed-but-unroutable packets
    always_comb begin
        drop_d = drop_q;
        if (rx_accept && !rx_routable && (drop_q != '1)) begin
            drop_d = drop_q + drop_one_lp;
        end
    end

    // state registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_q      <= '0;
            tx_v_q    <= 1'b0;
            tx_pkt_q  <= '0;
            rx_v_q    <= 1'b0;
            rx_ch_q   <= '0;
            rx_data_q <= '0;
            drop_q    <= '0;
        end else begin
            rr_q      <= rr_d;
            tx_v_q    <= tx_v_d;
            tx_pkt_q  <= tx_pkt_d;
            rx_v_q    <= rx_v_d;
            rx_ch_q   <= rx_ch_d;
            rx_data_q <= rx_data_d;
            drop_q    <= drop_d;
        end
    end

    assign fsb_out         = tx_pkt_q;
    assign io.fsb_data_o   = fsb_out;
    assign io.fsb_v_o      = tx_v_q;
    assign io.htif_ready_o = grant;
    assign io.htif_v_o     = htif_v_vec;
    assign io.htif_data_o  = rx_data_q;
    assign io.fsb_ready_o  = fsb_ready;
    assign io.drop_count_o = drop_q;

endmodule
